bus_ram: RTL and testbench

- Parametrised single-port synchronous RAM with a valid/ready request interface and a pipelined response path.
- Adds byte-lane writes, configurable read latency and a decoded address window with error response.
- Adds a hardware clear engine that zero-fills the array.
- Sits on the CPU data/instruction bus beside peripherals; replaces fixed 16-bit x 1024 RAM instances.

---
 rtl/bus_pkg.sv | 38 +++
 rtl/bus_ram_core.sv | 42 ++++
 rtl/bus_ram.sv | 220 ++++++++++++++++++++++
 tb/tb_bus_ram.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the CPU data/instruction interconnect:
// address/data widths, a response record, the RAM controller states
// and a clog2 helper usable in constant expressions.
package bus_pkg;

  // Default interconnect widths used by the CPU and its peripherals.
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  // Response record at the default bus width: strobe, error flag, read data.
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [BUS_DATA_W-1:0] data;
  } bus_rsp_t;

  // Controller states for bus-attached RAM blocks.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2
  } ram_state_t;

  // Ceiling log2; returns the index width needed for 'value' entries.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_ram_core.sv
// Byte-enabled single-port synchronous RAM array. One-cycle registered
// read with read-first behaviour: a write and its read data in the same
// cycle return the contents as they were before the write. Contents are
// never reset.
module ram_core
  import bus_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MEM_SIZE  = 1024,
  parameter     INIT_FILE = "",
  localparam int IDX_W    = clog2(MEM_SIZE),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_w_data,
  output logic [DATA_W-1:0] o_r_data
);

  logic [DATA_W-1:0] mem [MEM_SIZE];
  logic [DATA_W-1:0] r_data_reg;

  // Registered read of the old word, then byte-lane update on writes.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_data_reg <= mem[i_idx];
      if (i_we) begin
        for (int k = 0; k < BE_W; k++) begin
          if (i_be[k]) begin
            mem[i_idx][8*k +: 8] <= i_w_data[8*k +: 8];
          end
        end
      end
    end
  end

  assign o_r_data = r_data_reg;

endmodule

// File: rtl/bus_ram.sv
// Bus-attached RAM: decodes an address window, accepts one request per
// cycle on a valid/ready handshake and returns exactly one response per
// accept after READ_LAT cycles. Out-of-window accesses return an error
// and never touch the array. A clear engine zero-fills the array, then
// waits for in-flight responses to leave before accepting again.
module bus_ram
  import bus_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int MEM_SIZE  = 1024,
  parameter int READ_LAT  = 1,
  parameter     INIT_FILE = ""
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_we,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_w_data,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic                o_rsp_err,
  input  logic                i_clr,
  output logic                o_busy
);

  localparam int IDX_W  = clog2(MEM_SIZE);
  localparam int BE_W   = DATA_W / 8;
  localparam int AEXT_W = ADDR_W + 1;

  // Window bounds carry one extra bit so BASE_ADDR+MEM_SIZE may equal 2^ADDR_W.
  localparam logic [AEXT_W-1:0] WIN_LO = AEXT_W'(BASE_ADDR);
  localparam logic [AEXT_W-1:0] WIN_HI = AEXT_W'(BASE_ADDR + MEM_SIZE);

  localparam logic [IDX_W-1:0] CNT_LAST   = IDX_W'(MEM_SIZE - 1);
  localparam logic [1:0]       DRAIN_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  // Response record at this instance's data width.
  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  ram_state_t       state_reg;
  logic [IDX_W-1:0] clr_cnt_reg;
  logic [1:0]       drain_cnt_reg;
  logic             busy_reg;

  logic             s0_valid_reg;
  logic             s0_err_reg;
  logic             s0_rd_reg;

  logic [AEXT_W-1:0] addr_ext;
  logic              hit;
  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              clr_active;

  logic              ram_en;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_w_data;
  logic [DATA_W-1:0] ram_r_data;

  rsp_t              rsp_s0;
  rsp_t              rsp_out;
  logic              pipe_busy;

  // ---------------------------------------------------------------------
  // Address decode and handshake
  // ---------------------------------------------------------------------
  assign addr_ext = {1'b0, i_addr};
  assign hit      = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign req_idx  = IDX_W'(i_addr - ADDR_W'(BASE_ADDR));

  // A request coinciding with a clear start is refused so the clear
  // never overlaps a freshly accepted access.
  assign o_req_ready = (state_reg == ST_IDLE) && !i_clr && !i_rst;
  assign accept      = i_req_valid && o_req_ready;
  assign clr_active  = (state_reg == ST_CLEAR);

  // ---------------------------------------------------------------------
  // Array port: the clear engine owns the port while clearing
  // ---------------------------------------------------------------------
  assign ram_en     = clr_active || (accept && hit);
  assign ram_we     = clr_active || (accept && i_we);
  assign ram_be     = clr_active ? {BE_W{1'b1}} : i_be;
  assign ram_idx    = clr_active ? clr_cnt_reg : req_idx;
  assign ram_w_data = clr_active ? {DATA_W{1'b0}} : i_w_data;

  ram_core #(
    .DATA_W    (DATA_W),
    .MEM_SIZE  (MEM_SIZE),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .i_clk    (i_clk),
    .i_en     (ram_en),
    .i_we     (ram_we),
    .i_be     (ram_be),
    .i_idx    (ram_idx),
    .i_w_data (ram_w_data),
    .o_r_data (ram_r_data)
  );

  // ---------------------------------------------------------------------
  // Control FSM: IDLE accepts requests, CLEAR zero-fills, DRAIN waits
  // ---------------------------------------------------------------------
  // Sequences the clear engine and keeps o_busy registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      clr_cnt_reg   <= '0;
      drain_cnt_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_clr) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_reg == CNT_LAST) begin
            if (READ_LAT == 1) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg     <= ST_DRAIN;
              drain_cnt_reg <= DRAIN_INIT;
            end
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Fixed READ_LAT-1 cycle hold, extended if anything is still in flight.
          if ((drain_cnt_reg == 2'd0) && !pipe_busy) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (drain_cnt_reg != 2'd0) begin
            drain_cnt_reg <= drain_cnt_reg - 2'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = busy_reg;

  // ---------------------------------------------------------------------
  // Response stage 0: aligned with the array's one-cycle read
  // ---------------------------------------------------------------------
  // Records what kind of response the accepted request owes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s0_valid_reg <= 1'b0;
      s0_err_reg   <= 1'b0;
      s0_rd_reg    <= 1'b0;
    end else begin
      s0_valid_reg <= accept;
      s0_err_reg   <= accept && !hit;
      s0_rd_reg    <= accept && hit && !i_we;
    end
  end

  // Writes and misses return zero data; only in-window reads expose the array.
  assign rsp_s0 = {s0_valid_reg, s0_err_reg,
                   s0_rd_reg ? ram_r_data : {DATA_W{1'b0}}};

  // ---------------------------------------------------------------------
  // Extra latency stages carrying {valid, err, data}
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    if (READ_LAT == 1) begin : g_direct
      assign rsp_out   = rsp_s0;
      assign pipe_busy = s0_valid_reg;
    end else begin : g_pipe
      rsp_t                pipe_reg [READ_LAT-1];
      logic [READ_LAT-2:0] pipe_vld;

      for (gi = 0; gi < READ_LAT - 1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          // First delay stage takes the array-aligned response.
          always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) pipe_reg[gi] <= '0;
            else       pipe_reg[gi] <= rsp_s0;
          end
        end else begin : g_next
          // Later stages shift the response one cycle further.
          always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) pipe_reg[gi] <= '0;
            else       pipe_reg[gi] <= pipe_reg[gi-1];
          end
        end
        assign pipe_vld[gi] = pipe_reg[gi].valid;
      end

      assign rsp_out   = pipe_reg[READ_LAT-2];
      assign pipe_busy = s0_valid_reg || (|pipe_vld);
    end
  endgenerate

  assign o_rsp_valid = rsp_out.valid;
  assign o_rsp_err   = rsp_out.err;
  assign o_rsp_data  = rsp_out.data;

endmodule

// File: tb/tb_bus_ram.sv
// Scoreboard bench for bus_ram. Two instances (READ_LAT=1 and READ_LAT=3,
// window 0x100..0x4FF) see identical stimulus; every issued request pushes
// its hand-computed response onto each instance's queue and a monitor pops
// and compares whenever an instance raises o_rsp_valid.
module tb_bus_ram;

  typedef struct {
    int          due;
    logic        err;
    logic [15:0] data;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        we;
  logic [1:0]  be;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        clr;

  logic        ready [2];
  logic        rv    [2];
  logic        re    [2];
  logic        busy  [2];
  logic [15:0] rd    [2];

  int   lat [2] = '{1, 3};
  exp_t q   [2][$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bus_ram #(
    .DATA_W(16), .ADDR_W(16), .BASE_ADDR(32'h100), .MEM_SIZE(1024),
    .READ_LAT(1), .INIT_FILE("")
  ) u_lat1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready[0]),
    .i_we(we), .i_be(be), .i_addr(addr), .i_w_data(wdata),
    .o_rsp_valid(rv[0]), .o_rsp_data(rd[0]), .o_rsp_err(re[0]),
    .i_clr(clr), .o_busy(busy[0])
  );

  bus_ram #(
    .DATA_W(16), .ADDR_W(16), .BASE_ADDR(32'h100), .MEM_SIZE(1024),
    .READ_LAT(3), .INIT_FILE("")
  ) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready[1]),
    .i_we(we), .i_be(be), .i_addr(addr), .i_w_data(wdata),
    .o_rsp_valid(rv[1]), .o_rsp_data(rd[1]), .o_rsp_err(re[1]),
    .i_clr(clr), .o_busy(busy[1])
  );

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pop and compare one expected response per strobe.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rv[d]) begin
        if (q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL L%0d unexpected response cyc=%0d data=%h err=%b",
                   lat[d], cyc, rd[d], re[d]);
        end else begin
          e = q[d].pop_front();
          $display("rsp L%0d %s cyc=%0d data=%h err=%b", lat[d], e.name, cyc, rd[d], re[d]);
          chk($sformatf("L%0d %s cycle", lat[d], e.name), cyc, e.due);
          chk($sformatf("L%0d %s data", lat[d], e.name), {16'h0, rd[d]}, {16'h0, e.data});
          chk($sformatf("L%0d %s err", lat[d], e.name), {31'h0, re[d]}, {31'h0, e.err});
        end
      end
    end
  end

  // Drives one request for one cycle (back-to-back when called in a row).
  task automatic issue(input string name, input logic w, input logic [1:0] b,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic xerr, input logic [15:0] xdata);
    int waited = 0;
    while (!(ready[0] && ready[1]) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!(ready[0] && ready[1])) begin
      chk({name, " ready wait"}, {30'h0, ready[0], ready[1]}, 32'h3);
    end else begin
      req_valid = 1'b1;
      we        = w;
      be        = b;
      addr      = a;
      wdata     = wd;
      for (int d = 0; d < 2; d++)
        q[d].push_back('{due: cyc + lat[d], err: xerr, data: xdata, name: name});
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("L%0d %s ready", lat[d], tag), {31'h0, ready[d]}, 32'h0);
      chk($sformatf("L%0d %s rsp_valid", lat[d], tag), {31'h0, rv[d]}, 32'h0);
      chk($sformatf("L%0d %s busy", lat[d], tag), {31'h0, busy[d]}, 32'h0);
      chk($sformatf("L%0d %s rsp_data", lat[d], tag), {16'h0, rd[d]}, 32'h0);
      chk($sformatf("L%0d %s rsp_err", lat[d], tag), {31'h0, re[d]}, 32'h0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n_busy [2];
    int rdy_bad;
    int guard;

    rst = 1'b1; req_valid = 1'b0; we = 1'b0; be = 2'b00;
    addr = 16'h0; wdata = 16'h0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("L%0d ready after reset", lat[d]), {31'h0, ready[d]}, 32'h1);

    // Basic write/read and byte lanes
    issue("wr 105 BEEF",   1'b1, 2'b11, 16'h105, 16'hBEEF, 1'b0, 16'h0000);
    issue("rd 105",        1'b0, 2'b00, 16'h105, 16'h0000, 1'b0, 16'hBEEF);
    issue("wr 105 be01",   1'b1, 2'b01, 16'h105, 16'h1234, 1'b0, 16'h0000);
    issue("rd 105 lane0",  1'b0, 2'b00, 16'h105, 16'h0000, 1'b0, 16'hBE34);
    issue("wr 105 be00",   1'b1, 2'b00, 16'h105, 16'hFFFF, 1'b0, 16'h0000);
    issue("rd 105 nobe",   1'b0, 2'b00, 16'h105, 16'h0000, 1'b0, 16'hBE34);

    // Window decode: misses must not alias onto in-window words
    issue("wr 100 1111",   1'b1, 2'b11, 16'h100, 16'h1111, 1'b0, 16'h0000);
    issue("wr 4FF 7777",   1'b1, 2'b11, 16'h4FF, 16'h7777, 1'b0, 16'h0000);
    issue("wr 106 5555",   1'b1, 2'b11, 16'h106, 16'h5555, 1'b0, 16'h0000);
    issue("rd 0FF miss",   1'b0, 2'b00, 16'h0FF, 16'h0000, 1'b1, 16'h0000);
    issue("rd 500 miss",   1'b0, 2'b00, 16'h500, 16'h0000, 1'b1, 16'h0000);
    issue("wr 0FF miss",   1'b1, 2'b11, 16'h0FF, 16'hAAAA, 1'b1, 16'h0000);
    issue("wr 500 miss",   1'b1, 2'b11, 16'h500, 16'hBBBB, 1'b1, 16'h0000);
    issue("rd 4FF",        1'b0, 2'b00, 16'h4FF, 16'h0000, 1'b0, 16'h7777);
    issue("rd 100",        1'b0, 2'b00, 16'h100, 16'h0000, 1'b0, 16'h1111);
    issue("rd 106",        1'b0, 2'b00, 16'h106, 16'h0000, 1'b0, 16'h5555);
    issue("rd 105 again",  1'b0, 2'b00, 16'h105, 16'h0000, 1'b0, 16'hBE34);

    // Preload 0x100..0x107 with i, then eight back-to-back reads
    for (int i = 0; i < 8; i++)
      issue($sformatf("wr %0h", 16'h100 + i), 1'b1, 2'b11, 16'(16'h100 + i), 16'(i), 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++)
      issue($sformatf("rd %0h", 16'h100 + i), 1'b0, 2'b00, 16'(16'h100 + i), 16'h0000, 1'b0, 16'(i));
    issue("wr 107 be10",   1'b1, 2'b10, 16'h107, 16'hAB99, 1'b0, 16'h0000);
    issue("rd 107 lane1",  1'b0, 2'b00, 16'h107, 16'h0000, 1'b0, 16'hAB07);

    // Clear with a read in flight and a refused request in the start cycle
    issue("rd 101 preclr", 1'b0, 2'b00, 16'h101, 16'h0000, 1'b0, 16'h0001);
    clr = 1'b1; req_valid = 1'b1; we = 1'b0; addr = 16'h102;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("L%0d ready with clr", lat[d]), {31'h0, ready[d]}, 32'h0);
    @(negedge clk);
    clr = 1'b0; req_valid = 1'b0;
    n_busy = '{0, 0};
    rdy_bad = 0;
    guard = 0;
    while ((busy[0] || busy[1]) && guard < 3000) begin
      for (int d = 0; d < 2; d++) begin
        if (busy[d]) begin
          n_busy[d]++;
          if (ready[d]) rdy_bad++;
        end
      end
      @(negedge clk);
      guard++;
    end
    chk("L1 busy cycles", n_busy[0], 1024);
    chk("L3 busy cycles", n_busy[1], 1026);
    chk("ready while busy", rdy_bad, 0);
    issue("rd 100 clr",    1'b0, 2'b00, 16'h100, 16'h0000, 1'b0, 16'h0000);
    issue("rd 2FF clr",    1'b0, 2'b00, 16'h2FF, 16'h0000, 1'b0, 16'h0000);
    issue("rd 4FF clr",    1'b0, 2'b00, 16'h4FF, 16'h0000, 1'b0, 16'h0000);

    // Reset in the middle of a clear, with counter at 10
    issue("wr 105 5A5A",   1'b1, 2'b11, 16'h105, 16'h5A5A, 1'b0, 16'h0000);
    issue("wr 109 0909",   1'b1, 2'b11, 16'h109, 16'h0909, 1'b0, 16'h0000);
    issue("wr 10A 0A0A",   1'b1, 2'b11, 16'h10A, 16'h0A0A, 1'b0, 16'h0000);
    issue("wr 10B 0B0B",   1'b1, 2'b11, 16'h10B, 16'h0B0B, 1'b0, 16'h0000);
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("L%0d busy before abort", lat[d]), {31'h0, busy[d]}, 32'h1);
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue("rd 105 abort",  1'b0, 2'b00, 16'h105, 16'h0000, 1'b0, 16'h0000);
    issue("rd 109 abort",  1'b0, 2'b00, 16'h109, 16'h0000, 1'b0, 16'h0000);
    issue("rd 10A abort",  1'b0, 2'b00, 16'h10A, 16'h0000, 1'b0, 16'h0A0A);
    issue("rd 10B abort",  1'b0, 2'b00, 16'h10B, 16'h0000, 1'b0, 16'h0B0B);

    // Read-first ordering around a write to the same word
    issue("wr 10B CCCC",   1'b1, 2'b11, 16'h10B, 16'hCCCC, 1'b0, 16'h0000);
    issue("rd 10B new",    1'b0, 2'b00, 16'h10B, 16'h0000, 1'b0, 16'hCCCC);

    repeat (8) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("L%0d responses outstanding", lat[d]), q[d].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
